route_ctrl_east: RTL
====================

# route_ctrl_east

East input-port controller of the mesh router, directly downstream of the east input FIFO. It pops 8-bit flits from the FIFO, decodes the head flit and computes an XY route. It then requests the selected output port and streams the packet (head, body, tail) to the crossbar once that port is granted. Packets whose route is illegal for an east input are drained and flagged.

## Interface
- X_POS, 3'd1, this router's mesh column
- Y_POS, 3'd1, this router's mesh row
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- fifo_empty  in  1  east FIFO has no flits (from buffer wrapper)
- fifo_read  out  1  pop request to east FIFO
- fifo_data  in  8  FIFO registered output; valid the cycle after fifo_read
- req  out  5  one-hot output-port request: [0] local, [1] north, [2] south, [3] east, [4] west
- grant  in  5  one-hot grant from output arbiters
- out_ready  in  1  crossbar/downstream accepts flit this cycle
- flit_out  out  8  flit to crossbar
- flit_valid  out  1  flit_out valid
- route_err  out  1  one-cycle pulse on malformed or illegal packet
- busy  out  1  FSM not in IDLE

## Operation
- Flit format: [7:6] type: 00 invalid, 01 head, 10 body, 11 tail. Head [5:3] dst_x, [2:0] dst_y. Packet = head, zero or more body, tail (minimum 2 flits).
- XY route, unsigned 3-bit compares:
  - dst_x < X_POS → west.
  - dst_x == X_POS → north if dst_y > Y_POS, south if dst_y < Y_POS, local if equal.
  - dst_x > X_POS → illegal (U-turn to east); req[3] is never asserted.
- FSM states:
  - IDLE: fifo_read = !fifo_empty; on read → HEAD.
  - HEAD: sample fifo_data into hold register.
    - type != 01 → route_err pulse, discard, → IDLE.
    - illegal route → route_err pulse, → DROP.
    - otherwise latch dir, → REQ.
  - REQ: req[dir]=1; on grant[dir] → SEND.
  - SEND: flit_out = hold; flit_valid = grant[dir]. On flit_valid & out_ready:
    - hold is tail → IDLE.
    - else if !fifo_empty → assert fifo_read, → LOAD.
    - else → FETCH.
  - FETCH: fifo_read = !fifo_empty; on read → LOAD.
  - LOAD: hold ← fifo_data, → SEND.
  - DROP: fifo_read = !fifo_empty; on read → DROP_CHK.
  - DROP_CHK: fifo_data type 11 → IDLE, else → DROP.
- req[dir] stays high from REQ through the cycle the tail is accepted; all req bits are 0 in IDLE, HEAD, DROP and DROP_CHK.
- Grant deasserted mid-packet: flit_valid drops, FSM holds in SEND, req stays high.
- Body or tail flit arriving in HEAD: discarded with route_err pulse.
- Head flit arriving mid-packet (LOAD): forwarded as data; no checking.

## Timing
- Reset values: fifo_read 0, req 0, flit_out 8'h00, flit_valid 0, route_err 0, busy 0, FSM IDLE, hold 0.
- fifo_read, req, flit_valid, busy: combinational from state and inputs. flit_out and route_err are registered.
- Head latency, FIFO non-empty with grant available at once:
  - fifo_read in cycle 0, HEAD in cycle 1, REQ in cycle 2.
  - Grant seen in cycle 2 → head flit_valid in cycle 3.
- Streaming throughput with FIFO non-empty and out_ready=1: one flit per 2 cycles (SEND, LOAD).
- Exactly one fifo_read per flit popped. fifo_read is never asserted while fifo_empty=1.
- route_err is high for exactly one cycle, in the cycle after HEAD rejects the flit.
- Reset during any state: IDLE next cycle, all outputs at reset values. The remainder of an interrupted packet is later rejected flit by flit via HEAD, with one route_err per flit.

## Test plan
- X_POS=1, Y_POS=1. Push head 8'h48 (dst 1,0), body 8'h95, tail 8'hC3. Grant south when req=5'b00100. Expected: flit_out sequence 48, 95, C3, each with flit_valid; req clears after tail; one fifo_read per flit.
- Head 8'h41 (dst 0,1). Expected: req=5'b10000 (west). Withhold grant 5 cycles: flit_valid stays 0, req held. Then grant: head is sent in the cycle after grant.
- Head 8'h50 (dst 2,0) plus 3 body flits and a tail. Expected: route_err single pulse, req stays 0, all 5 flits popped and dropped, then IDLE.
- Body 8'h80 presented as the first flit. Expected: route_err pulse, discarded, busy returns to 0.
- Deassert out_ready and grant for 3 cycles mid-packet, with the FIFO emptying between flits. Expected: no flit lost or duplicated, no fifo_read while empty, order preserved.
- Assert rst=0 while in SEND on a body flit. Expected: next cycle all outputs 0. The leftover tail then yields one route_err.

Source files
------------

// File: rtl/route_ctrl_east.sv
// East input-port controller: pops flits from the east FIFO, XY-routes the head flit,
// requests the chosen output port and streams the packet once granted.
module route_ctrl_east #(
  parameter logic [2:0] X_POS = 3'd1,
  parameter logic [2:0] Y_POS = 3'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  output logic       fifo_read,
  input  logic [7:0] fifo_data,
  output logic [4:0] req,
  input  logic [4:0] grant,
  input  logic       out_ready,
  output logic [7:0] flit_out,
  output logic       flit_valid,
  output logic       route_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StHead,
    StReq,
    StSend,
    StFetch,
    StLoad,
    StDrop,
    StDropChk
  } state_e;

  localparam logic [1:0] TypeHead = 2'b01;
  localparam logic [1:0] TypeTail = 2'b11;

  localparam logic [4:0] DirLocal = 5'b00001;
  localparam logic [4:0] DirNorth = 5'b00010;
  localparam logic [4:0] DirSouth = 5'b00100;
  localparam logic [4:0] DirWest  = 5'b10000;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [4:0] dir_q, dir_d;
  logic       route_err_d;

  logic [2:0] dst_x, dst_y;
  logic [4:0] route_dir;
  logic       route_ok;

  logic       fifo_read_c;
  logic [4:0] req_c;
  logic       flit_valid_c;

  assign dst_x = fifo_data[5:3];
  assign dst_y = fifo_data[2:0];

  // XY routing; a destination further east would be a U-turn back out the east port.
  always_comb begin
    route_dir = '0;
    route_ok  = 1'b1;
    if (dst_x < X_POS) begin
      route_dir = DirWest;
    end else if (dst_x == X_POS) begin
      if (dst_y > Y_POS) begin
        route_dir = DirNorth;
      end else if (dst_y < Y_POS) begin
        route_dir = DirSouth;
      end else begin
        route_dir = DirLocal;
      end
    end else begin
      route_ok = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    dir_d        = dir_q;
    route_err_d  = 1'b0;
    fifo_read_c  = 1'b0;
    req_c        = '0;
    flit_valid_c = 1'b0;

    unique case (state_q)
      StIdle: begin
        fifo_read_c = !fifo_empty;
        if (!fifo_empty) begin
          state_d = StHead;
        end
      end
      StHead: begin
        if (fifo_data[7:6] != TypeHead) begin
          route_err_d = 1'b1;
          state_d     = StIdle;
        end else if (!route_ok) begin
          route_err_d = 1'b1;
          state_d     = StDrop;
        end else begin
          hold_d  = fifo_data;
          dir_d   = route_dir;
          state_d = StReq;
        end
      end
      StReq: begin
        req_c = dir_q;
        if ((grant & dir_q) != '0) begin
          state_d = StSend;
        end
      end
      StSend: begin
        req_c        = dir_q;
        flit_valid_c = (grant & dir_q) != '0;
        if (flit_valid_c && out_ready) begin
          if (hold_q[7:6] == TypeTail) begin
            state_d = StIdle;
          end else if (!fifo_empty) begin
            fifo_read_c = 1'b1;
            state_d     = StLoad;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        req_c       = dir_q;
        fifo_read_c = !fifo_empty;
        if (!fifo_empty) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        req_c   = dir_q;
        hold_d  = fifo_data;
        state_d = StSend;
      end
      StDrop: begin
        fifo_read_c = !fifo_empty;
        if (!fifo_empty) begin
          state_d = StDropChk;
        end
      end
      StDropChk: begin
        state_d = (fifo_data[7:6] == TypeTail) ? StIdle : StDrop;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Hold all handshake outputs quiet while reset is asserted so no flit is popped or sent.
  assign fifo_read  = rst & fifo_read_c;
  assign req        = rst ? req_c : '0;
  assign flit_valid = rst & flit_valid_c;
  assign busy       = rst & (state_q != StIdle);
  assign flit_out   = hold_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      dir_q     <= '0;
      route_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      dir_q     <= dir_d;
      route_err <= route_err_d;
    end
  end

endmodule
